// File: rtl/mem_arbiter_if.sv
// Bus bundle tying the IF/MEM requesters and the unified memory to mem_arbiter.
// slave: arbiter side; master: pipeline stages plus memory.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_valid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_valid;
  logic [DW-1:0] d_rdata;

  logic          mem_enable;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  logic          busy;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_wr, d_addr, d_wdata,
    input  mem_data_out,
    output i_valid, i_rdata,
    output d_valid, d_rdata,
    output mem_enable, mem_wr, mem_addr, mem_data_in,
    output busy
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_wr, d_addr, d_wdata,
    output mem_data_out,
    input  i_valid, i_rdata,
    input  d_valid, d_rdata,
    input  mem_enable, mem_wr, mem_addr, mem_data_in,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between IF reads and MEM reads/writes.
// Define ARB_ROUND_ROBIN_EN to alternate on ties; otherwise MEM always wins a tie.
//
// state | meaning
// IDLE  | no access in flight; a pending req is granted and latched here
// GRANT | memory access in flight; count runs down to the completion cycle
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  // LATENCY is legal in 1..15, so the load value always fits the 4-bit counter.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [3:0]    count_q, count_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          grant;
  logic          done;
  logic          pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  // On a tie the requester not served last goes next; a lone requester always wins.
  assign pick_d = bus.d_req && (!bus.i_req || !last_d_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && (bus.i_req || bus.d_req)) begin
      last_d_d = pick_d;
    end
  end
`else
  // MEM holds the older instruction, so it wins every tie.
  assign pick_d = bus.d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      count_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    count_d = count_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d = GRANT;
          count_d = CNT_LOAD;
          if (pick_d) begin
            owner_d = OWN_D;
            addr_d  = bus.d_addr;
            wr_d    = bus.d_wr;
            wdata_d = bus.d_wdata;
          end else begin
            owner_d = OWN_I;
            addr_d  = bus.i_addr;
            wr_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      GRANT: begin
        if (count_q == 4'd0) begin
          done    = 1'b1;
          state_d = IDLE;
          owner_d = OWN_NONE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign grant = (state_q == GRANT);

  // The memory side sees only latched values, so requester inputs may wander mid-access.
  assign bus.mem_enable  = grant;
  assign bus.mem_wr      = grant && wr_q;
  assign bus.mem_addr    = grant ? addr_q : '0;
  assign bus.mem_data_in = grant ? wdata_q : '0;
  assign bus.busy        = grant;

  assign bus.i_valid = done && (owner_q == OWN_I);
  assign bus.d_valid = done && (owner_q == OWN_D);
  assign bus.i_rdata = bus.i_valid ? bus.mem_data_out : '0;
  assign bus.d_rdata = (bus.d_valid && !wr_q) ? bus.mem_data_out : '0;

endmodule
